// File: rtl/axi_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_slave_pkg
// Shared AXI encodings for the burst memory slave: burst types, response
// codes and the write/read FSM state encodings, plus a small helper that
// tells whether a burst type is one the slave actually services.
// -----------------------------------------------------------------------------
package axi_slave_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   // Only FIXED and INCR are serviced; WRAP and the reserved code error out.
   function automatic logic burst_ok(input logic [1:0] burst);
      return (burst == BURST_FIXED) || (burst == BURST_INCR);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Next word index for one burst beat, plus an out-of-range flag.
//   i_idx      : current word index (one bit wider than the address needs)
//   i_burst    : AXI burst type
//   o_next_idx : index for the following beat (INCR +1, otherwise held)
//   o_oor      : current index is outside the memory (index >= DEPTH)
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
   import axi_slave_pkg::*;
#(
   parameter int IDX_W = 9,
   parameter int DEPTH = 64
) (
   input  logic [IDX_W-1:0] i_idx,
   input  logic [1:0]       i_burst,
   output logic [IDX_W-1:0] o_next_idx,
   output logic             o_oor
);

   assign o_next_idx = (i_burst == BURST_INCR) ? i_idx + IDX_W'(1) : i_idx;
   assign o_oor      = (i_idx >= IDX_W'(DEPTH));

endmodule

// File: rtl/axi_burst_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_burst_mem_slave
// AXI4 scratch-memory slave: FIXED/INCR bursts up to 256 beats, byte strobes,
// per-word written flags, per-beat SLVERR/DECERR, independent read and write.
// Ports:
//   aclk, areset                        clock, async active-high reset
//   aw* / w* / b*                       write address, data, response channels
//   ar* / r*                            read address and data channels
// -----------------------------------------------------------------------------
module axi_burst_mem_slave
   import axi_slave_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int DEPTH  = 64
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);

   localparam int STRB_W  = DATA_W / 8;
   localparam int OFF_W   = $clog2(STRB_W);
   localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int A_IDX_W = ADDR_W - OFF_W;
   // One spare bit so INCR overruns past the top never wrap back into range.
   localparam int IDX_W   = ((A_IDX_W > MEM_AW) ? A_IDX_W : MEM_AW) + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_flag;

   // ---------------------------------------------------------------- write --
   w_state_t          r_wstate;
   logic              r_awready, r_wready, r_bvalid;
   logic [ID_W-1:0]   r_bid;
   logic [1:0]        r_bresp;
   logic [IDX_W-1:0]  r_w_idx;
   logic [7:0]        r_w_len, r_w_cnt;
   logic [1:0]        r_w_burst;
   logic              r_w_dec, r_w_slv;

   logic [IDX_W-1:0]  w_w_next_idx;
   logic              w_w_oor, w_w_hs, w_w_we, w_w_last_beat, w_w_slv_beat;
   logic [MEM_AW-1:0] w_w_widx;

   axi_burst_addr_gen #(.IDX_W(IDX_W), .DEPTH(DEPTH)) u_aw_gen (
      .i_idx      (r_w_idx),
      .i_burst    (r_w_burst),
      .o_next_idx (w_w_next_idx),
      .o_oor      (w_w_oor)
   );

   assign w_w_hs        = wvalid & r_wready;
   assign w_w_last_beat = (r_w_cnt == r_w_len);
   assign w_w_we        = w_w_hs & burst_ok(r_w_burst) & ~w_w_oor;
   // The burst length is authoritative; wlast only feeds the error check.
   assign w_w_slv_beat  = ~burst_ok(r_w_burst) | (wlast != w_w_last_beat);
   assign w_w_widx      = r_w_idx[MEM_AW-1:0];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b1;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= RESP_OKAY;
         r_w_idx   <= '0;
         r_w_len   <= '0;
         r_w_cnt   <= '0;
         r_w_burst <= BURST_FIXED;
         r_w_dec   <= 1'b0;
         r_w_slv   <= 1'b0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (awvalid) begin
                  r_bid     <= awid;
                  r_w_idx   <= IDX_W'(awaddr >> OFF_W);
                  r_w_len   <= awlen;
                  r_w_burst <= awburst;
                  r_w_cnt   <= '0;
                  r_w_dec   <= 1'b0;
                  r_w_slv   <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  r_w_idx <= w_w_next_idx;
                  r_w_cnt <= r_w_cnt + 8'd1;
                  r_w_dec <= r_w_dec | w_w_oor;
                  r_w_slv <= r_w_slv | w_w_slv_beat;
                  if (w_w_last_beat) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_w_dec | w_w_oor)      ? RESP_DECERR :
                                 (r_w_slv | w_w_slv_beat) ? RESP_SLVERR : RESP_OKAY;
                     r_wstate <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // NOTE: the data array carries no reset (it maps onto plain RAM); validity
   // is tracked by the separately reset flag vector instead.
   always_ff @(posedge aclk) begin
      if (w_w_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) r_mem[w_w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset)      r_flag <= '0;
      else if (w_w_we) r_flag[w_w_widx] <= 1'b1;
   end

   // ----------------------------------------------------------------- read --
   r_state_t          r_rstate;
   logic              r_arready, r_rvalid, r_rlast;
   logic [ID_W-1:0]   r_rid;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_rresp;
   logic [IDX_W-1:0]  r_r_idx;
   logic [7:0]        r_r_len, r_r_cnt;
   logic [1:0]        r_r_burst;

   logic [IDX_W-1:0]  w_r_src_idx, w_r_next_idx;
   logic [1:0]        w_r_src_burst;
   logic              w_r_oor;
   logic [MEM_AW-1:0] w_r_ridx;
   logic [DATA_W-1:0] w_r_beat_data;
   logic [1:0]        w_r_beat_resp;

   // In IDLE the beat being loaded is the first one, straight from AR.
   assign w_r_src_idx   = (r_rstate == R_IDLE) ? IDX_W'(araddr >> OFF_W) : r_r_idx;
   assign w_r_src_burst = (r_rstate == R_IDLE) ? arburst : r_r_burst;
   assign w_r_ridx      = w_r_src_idx[MEM_AW-1:0];

   axi_burst_addr_gen #(.IDX_W(IDX_W), .DEPTH(DEPTH)) u_ar_gen (
      .i_idx      (w_r_src_idx),
      .i_burst    (w_r_src_burst),
      .o_next_idx (w_r_next_idx),
      .o_oor      (w_r_oor)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_r_beat_resp = RESP_OKAY;
      w_r_beat_data = r_mem[w_r_ridx];
      if (w_r_oor) begin
         w_r_beat_resp = RESP_DECERR;
         w_r_beat_data = '0;
      end else if (!burst_ok(w_r_src_burst) || !r_flag[w_r_ridx]) begin
         w_r_beat_resp = RESP_SLVERR;
         w_r_beat_data = '0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_r_idx   <= '0;
         r_r_len   <= '0;
         r_r_cnt   <= '0;
         r_r_burst <= BURST_FIXED;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (arvalid) begin
                  r_rid     <= arid;
                  r_r_len   <= arlen;
                  r_r_burst <= arburst;
                  r_r_cnt   <= '0;
                  r_r_idx   <= w_r_next_idx;
                  r_rdata   <= w_r_beat_data;
                  r_rresp   <= w_r_beat_resp;
                  r_rlast   <= (arlen == 8'd0);
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
                  r_rstate  <= R_DATA;
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_rstate  <= R_IDLE;
                  end else begin
                     r_r_cnt <= r_r_cnt + 8'd1;
                     r_r_idx <= w_r_next_idx;
                     r_rdata <= w_r_beat_data;
                     r_rresp <= w_r_beat_resp;
                     r_rlast <= ((r_r_cnt + 8'd1) == r_r_len);
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_bvalid;
   assign bid     = r_bid;
   assign bresp   = r_bresp;
   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rlast   = r_rlast;
   assign rid     = r_rid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;

endmodule
